// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared states, widths and constants for the divider scheduler.
package div_sched_pkg;

    localparam int DIVIDEND_W = 10;
    localparam int DIVISOR_W  = 3;
    localparam int QUOT_W     = 20;
    localparam logic [QUOT_W-1:0] ZERO_DIV_RESULT = 20'hFFFFF;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_RESP} state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_sched_rr_arb.sv
// div_sched_rr_arb: combinational rotating-priority picker, searching upward from rr_ptr with wrap.
module div_sched_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0] j;
    logic            found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        j        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                grant_id = j;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one serial divider among NUM_REQ requesters.
// Optional watchdog on the WAIT state is compiled in with DIV_SCHED_WATCHDOG_EN.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ISSUE_CYCLES = 1,
    parameter int TIMEOUT      = 64,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DIVIDEND_W-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_W-1:0]  req_divisor,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [ID_W-1:0]               resp_id,
    output logic [QUOT_W-1:0]             resp_data,
    output logic                          resp_err,
    input  logic                          resp_ready,
    output logic                          div_in_valid,
    output logic [DIVIDEND_W-1:0]         div_in_data_1,
    output logic [DIVISOR_W-1:0]          div_in_data_2,
    input  logic                          div_out_valid,
    input  logic [QUOT_W-1:0]             div_out_data,
    output logic                          busy
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || ISSUE_CYCLES < 1 || ISSUE_CYCLES > 4 || TIMEOUT < 1) begin : g_param_check
        $error("div_sched: parameter out of range");
    end

    state_t                  state, state_nx;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id, rr_ptr;
    logic [DIVIDEND_W-1:0]   dividend_sel;
    logic [DIVISOR_W-1:0]    divisor_sel;
    logic [1:0]              issue_cnt;
    logic                    accept, zero_div, wd_hit;

    div_sched_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req      (req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        dividend_sel = '0;
        divisor_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                dividend_sel = req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
                divisor_sel  = req_divisor[i*DIVISOR_W +: DIVISOR_W];
            end
        end
    end

    // grant is only non-zero for valid requesters, so any grant in IDLE is an acceptance
    assign accept       = (state == S_IDLE) && |grant;
    assign zero_div     = divisor_sel == '0;
    assign req_ready    = (state == S_IDLE && rst_n) ? grant : '0;
    assign resp_valid   = state == S_RESP;
    assign div_in_valid = state == S_ISSUE;
    assign busy         = state != S_IDLE;

`ifdef DIV_SCHED_WATCHDOG_EN
    logic [15:0] wd_cnt;
    assign wd_hit = wd_cnt == 16'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else
            wd_cnt <= (state == S_WAIT) ? wd_cnt + 16'd1 : 16'd0;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = accept ? (zero_div ? S_RESP : S_ISSUE) : S_IDLE;
            S_ISSUE: state_nx = (issue_cnt == 2'(ISSUE_CYCLES - 1)) ? S_WAIT : S_ISSUE;
            S_WAIT:  state_nx = (div_out_valid || wd_hit) ? S_DRAIN : S_WAIT;
            S_DRAIN: state_nx = div_out_valid ? S_DRAIN : S_RESP;
            S_RESP:  state_nx = resp_ready ? S_IDLE : S_RESP;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            issue_cnt     <= '0;
            resp_id       <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            div_in_data_1 <= '0;
            div_in_data_2 <= '0;
        end else begin
            state     <= state_nx;
            issue_cnt <= (state == S_ISSUE) ? issue_cnt + 2'd1 : 2'd0;
            if (accept) begin
                resp_id   <= grant_id;
                rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                resp_data <= zero_div ? ZERO_DIV_RESULT : '0;
                resp_err  <= zero_div;
            end else if (state == S_WAIT && div_out_valid) begin
                resp_data <= div_out_data;
                resp_err  <= 1'b0;
            end else if (state == S_WAIT && wd_hit) begin
                resp_data <= '0;
                resp_err  <= 1'b1;
            end
            // operands stay on the divider bus from ISSUE until DRAIN ends
            div_in_data_1 <= (accept && !zero_div) ? dividend_sel : (state_nx == S_RESP) ? '0 : div_in_data_1;
            div_in_data_2 <= (accept && !zero_div) ? divisor_sel  : (state_nx == S_RESP) ? '0 : div_in_data_2;
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: randomized self-checking bench for div_sched against a transaction-level reference model.
module tb_div_sched;

    localparam int N  = 4;
    localparam int IC = 2;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*10-1:0] req_dividend = '0;
    logic [N*3-1:0]  req_divisor = '0;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [19:0]   resp_data;
    logic          resp_err;
    logic          resp_ready = 1'b0;
    logic          div_in_valid;
    logic [9:0]    div_in_data_1;
    logic [2:0]    div_in_data_2;
    logic          div_out_valid = 1'b0;
    logic [19:0]   div_out_data = '0;
    logic          busy;

    div_sched #(.NUM_REQ(N), .ISSUE_CYCLES(IC), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_id       (resp_id),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .resp_ready    (resp_ready),
        .div_in_valid  (div_in_valid),
        .div_in_data_1 (div_in_data_1),
        .div_in_data_2 (div_in_data_2),
        .div_out_valid (div_out_valid),
        .div_out_data  (div_out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;
    int dvd[N];
    int dvs[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return 0;
    endfunction

    // lat = cycle after acceptance at which the divider raises out_valid (0 = never answers)
    task automatic txn(input logic [N-1:0] mask, input bit keep, input int lat, input int hold,
                       input int stall, input int rst_at);
        int j, in_cnt, in_first, r_c, exp_rc;
        logic [19:0] eq;
        logic        eerr;
        j = pick(mask);
        for (int i = 0; i < N; i++) begin
            req_dividend[i*10 +: 10] = 10'(dvd[i]);
            req_divisor[i*3 +: 3]    = 3'(dvs[i]);
        end
        req_valid = mask;
        resp_ready = 1'b0;
        #1;
        check("grant", 32'(req_ready), 32'(1 << j));
        eerr   = (dvs[j] == 0) || (lat == 0);
        eq     = (dvs[j] == 0) ? 20'hFFFFF : (lat == 0) ? 20'd0 : 20'(dvd[j] / dvs[j]);
        exp_rc = (dvs[j] == 0) ? 1 : (lat == 0) ? IC + 66 : lat + hold + 1;
        in_cnt = 0;
        in_first = 0;
        r_c = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) req_valid = '0;
            if (rst_at == c) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(busy), 0);
                check("rst_in_valid", 32'(div_in_valid), 0);
                check("rst_resp_valid", 32'(resp_valid), 0);
                check("rst_ready", 32'(req_ready), 0);
                check("rst_in_data", 32'(div_in_data_1), 0);
                @(negedge clk);
                rst_n = 1'b1;
                req_valid = '0;
                ptr_m = 0;
                return;
            end
            if (div_in_valid) begin
                in_cnt++;
                if (in_first == 0) in_first = c;
            end
            if (c == 1 && dvs[j] != 0) begin
                check("in_data_1", 32'(div_in_data_1), 32'(dvd[j]));
                check("in_data_2", 32'(div_in_data_2), 32'(dvs[j]));
            end
            if (resp_valid) begin
                r_c = c;
                break;
            end
            div_out_valid = (lat > 0) && (c >= lat) && (c < lat + hold);
            div_out_data  = div_out_valid ? 20'(div_in_data_1 / div_in_data_2) : 20'hABCDE;
        end
        div_out_valid = 1'b0;
        check("resp_cycle", 32'(r_c), 32'(exp_rc));
        check("in_cnt", 32'(in_cnt), (dvs[j] == 0) ? 0 : IC);
        check("in_first", 32'(in_first), (dvs[j] == 0) ? 0 : 1);
        ptr_m = (j + 1) % N;
        if (r_c == 0) return;
        check("resp_id", 32'(resp_id), 32'(j));
        check("resp_data", 32'(resp_data), 32'(eq));
        check("resp_err", 32'(resp_err), 32'(eerr));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 1);
            check("stall_id", 32'(resp_id), 32'(j));
            check("stall_data", 32'(resp_data), 32'(eq));
            check("stall_err", 32'(resp_err), 32'(eerr));
            check("stall_ready", 32'(req_ready), 0);
            check("stall_in_valid", 32'(div_in_valid), 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_valid", 32'(resp_valid), 0);
        check("post_busy", 32'(busy), 0);
        if (!keep) req_valid = '0;
    endtask

    initial begin
        req_valid = '1;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_resp_valid", 32'(resp_valid), 0);
        check("reset_in_valid", 32'(div_in_valid), 0);
        check("reset_resp", {11'd0, resp_err, resp_data}, 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // all requesters held valid: rotation 0,1,2,3,0
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = $urandom_range(0, 1023);
                dvs[i] = $urandom_range(1, 7);
            end
            txn('1, 1'b1, $urandom_range(IC + 1, 12), $urandom_range(1, 3), 0, 0);
        end
        req_valid = '0;
        @(negedge clk);

        dvd[2] = 100;
        dvs[2] = 4;
        txn(4'b0100, 1'b0, 25, 2, 0, 0);

        dvd[1] = 77;
        dvs[1] = 0;
        txn(4'b0010, 1'b0, 5, 1, 10, 0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                dvd[i] = $urandom_range(0, 1023);
                dvs[i] = $urandom_range(0, 7);
            end
            txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(IC + 1, 20),
                $urandom_range(1, 3), $urandom_range(0, 3), 0);
        end
        req_valid = '0;
        @(negedge clk);

        for (int i = 0; i < N; i++) dvs[i] = $urandom_range(1, 7);
        ptr_m = 2;
        txn(4'b0100, 1'b0, 0, 0, 0, IC + 4);
        txn('1, 1'b0, 6, 2, 0, 0);

`ifdef DIV_SCHED_WATCHDOG_EN
        for (int i = 0; i < N; i++) dvs[i] = $urandom_range(1, 7);
        txn(4'b1000, 1'b0, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one serial division unit between `NUM_REQ` requesters. It sits between the requester ports and the divider's `in_valid`/`in_data_1`/`in_data_2` → `out_valid`/`out_data` interface. It arbitrates, issues one operation at a time, captures the result and returns it tagged with the requester index. Zero divisors are rejected locally, and an optional watchdog recovers from a divider that never answers.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ISSUE_CYCLES`, default 1: cycles `div_in_valid` is held high per operation, 1..4.
- `TIMEOUT`, default 64: WAIT-state cycle limit when the watchdog is compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: request pending, one bit per requester.
- `req_dividend` in `NUM_REQ`*10: packed, requester i at [10i+9:10i].
- `req_divisor` in `NUM_REQ`*3: packed, requester i at [3i+2:3i].
- `req_ready` out `NUM_REQ`: at most one bit high; the request is accepted on `req_valid[i] & req_ready[i]`.
- `resp_valid` out 1: result available.
- `resp_id` out `ID_W` = max(1, clog2(`NUM_REQ`)): index of the requester that owns the result.
- `resp_data` out 20: quotient.
- `resp_err` out 1: 1 = zero divisor or timeout.
- `resp_ready` in 1: consumer accepts the result.
- `div_in_valid` out 1; `div_in_data_1` out 10; `div_in_data_2` out 3: divider request.
- `div_out_valid` in 1; `div_out_data` in 20: divider result. `div_out_valid` is a level held for one or more cycles.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
- **IDLE.** The arbiter selects the first requester with `req_valid` set, searching from pointer `rr_ptr` upward with wrap. `req_ready` for that requester is driven combinationally; all other bits are 0. On acceptance:
  - Latch dividend, divisor and id.
  - Set `rr_ptr` = (id+1) mod `NUM_REQ`.
  - If divisor == 0: go to RESP with `resp_err`=1 and `resp_data`=20'hFFFFF. The divider is not used.
  - Otherwise go to ISSUE.
- **ISSUE.** `div_in_valid`=1 for exactly `ISSUE_CYCLES` cycles, then WAIT.
- **WAIT.** The first cycle `div_out_valid`=1 captures `div_out_data` into `resp_data` with `resp_err`=0, then DRAIN.
- **DRAIN.** Stay until `div_out_valid`=0, then RESP. This guarantees a held-high `div_out_valid` is never captured twice.
- **RESP.** `resp_valid`=1. `resp_id`, `resp_data` and `resp_err` stay stable until `resp_valid & resp_ready`, then IDLE.
- `div_in_data_1` and `div_in_data_2` are registered. They hold the latched operands from ISSUE through DRAIN and are 0 otherwise.
- Every requester waits at most `NUM_REQ`-1 grants (no starvation).
- A requester that drops `req_valid` before acceptance loses nothing; no state is changed.
- Deassertion of `rst_n` at any time immediately returns the block to IDLE.
  - Reset values: `rr_ptr`=0, all outputs 0, `req_ready`=0 while `rst_n` is low.
  - The divider is reset by the same `rst_n`.

## Timing
- From acceptance in IDLE at cycle T:
  - `div_in_valid` is high in cycles T+1 .. T+`ISSUE_CYCLES`.
  - If `div_out_valid` first rises at cycle D and falls at cycle F, `resp_valid` is first high at F+1.
- Zero divisor: `resp_valid` is high at T+1.
- After the RESP handshake at cycle H, IDLE is at H+1 and the next acceptance can be at H+1.
- `req_ready` never asserts in the same cycle as `resp_valid`.

## Configuration
- `DIV_SCHED_WATCHDOG_EN` defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - When the counter reaches `TIMEOUT`-1 without `div_out_valid`, the next state is DRAIN with `resp_err`=1 and `resp_data`=0.
- `DIV_SCHED_WATCHDOG_EN` undefined: no counter; WAIT lasts until `div_out_valid` rises.

## Structure
- Package `div_sched_pkg` holds:
  - The state enum.
  - Constants `DIVIDEND_W`=10, `DIVISOR_W`=3, `QUOT_W`=20.
  - The zero-divisor result 20'hFFFFF.
- Sub-module `div_sched_rr_arb`: combinational rotating-priority picker. Inputs are the request vector and `rr_ptr`; outputs are a one-hot grant and the grant index.

## Test plan
- Requester 2 sends dividend 10'd100, divisor 3'd4; the divider model answers after 25 cycles, holding `div_out_valid` for 2 cycles. Required: exactly one `resp_valid` handshake, `resp_id`=2, `resp_data` equal to the model value, `resp_err`=0.
- All 4 requesters hold `req_valid` continuously. Required grant order is 0,1,2,3,0 from reset; after a grant to 3 the next grant is 0.
- Requester 1 sends divisor 0. Required: `resp_valid` the cycle after acceptance, `resp_data`=20'hFFFFF, `resp_err`=1, `div_in_valid` never asserted.
- `resp_ready` is held low for 10 cycles in RESP. Required: outputs stable, all `req_ready` bits low, `div_in_valid` low.
- With `DIV_SCHED_WATCHDOG_EN` and `TIMEOUT`=64, the divider never answers. Required: `resp_err`=1 and `resp_data`=0 at cycle T+`ISSUE_CYCLES`+65.
- `rst_n` is pulsed low during WAIT. Required: `busy`, `div_in_valid` and `resp_valid` go to 0 asynchronously; the next grant is from `rr_ptr`=0.
